// File: rtl/sys_defs_pkg.sv
// rtl/sys_defs_pkg.sv - shared lane geometry, fixed-point format and RMS state encoding
package sys_defs;

  localparam int ARR_WIDTH = 4;
  localparam int FXP_N     = 16;
  localparam int FXP_Q     = 8;

  typedef logic signed [FXP_N-1:0]   lane_t;
  typedef logic signed [2*FXP_N-1:0] prod_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_MEAN,
    ST_SQRT,
    ST_DONE
  } state_t;

endpackage

// File: rtl/rms_norm_stats_if.sv
// rtl/rms_norm_stats_if.sv - control, input beat and result bundle of rms_norm_stats
interface rms_norm_stats_if;
  import sys_defs::*;

  logic                  start;
  logic                  in_valid;
  logic                  in_ready;
  lane_t [ARR_WIDTH-1:0] in_vec;
  logic                  busy;
  logic                  done;
  lane_t [ARR_WIDTH-1:0] rms_out;
  logic                  zro;
  logic                  ovf;

  modport master (
    output start, in_valid, in_vec,
    input  in_ready, busy, done, rms_out, zro, ovf
  );

  modport slave (
    input  start, in_valid, in_vec,
    output in_ready, busy, done, rms_out, zro, ovf
  );

endinterface

// File: rtl/fxp_isqrt.sv
// rtl/fxp_isqrt.sv - bit-serial restoring integer square root, one result bit per cycle
module fxp_isqrt #(
  parameter int IN_W = 34
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [IN_W-1:0]   din,
  output logic              done,
  output logic [IN_W/2-1:0] root
);

  localparam int RES_W = IN_W / 2;
  localparam int REM_W = RES_W + 2;
  localparam int CNT_W = $clog2(RES_W + 1);

  logic [IN_W-1:0]  op;
  logic [REM_W-1:0] rem;
  logic [CNT_W-1:0] cnt;
  logic [REM_W-1:0] trial;
  logic [REM_W-1:0] test;
  logic             ge;

  // Bring down the next two operand bits and try subtracting 4*root+1.
  always_comb begin
    trial = REM_W'({rem, op[IN_W-1:IN_W-2]});
    test  = {root, 2'b01};
    ge    = trial >= test;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op   <= '0;
      rem  <= '0;
      root <= '0;
      cnt  <= '0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        op   <= din;
        rem  <= '0;
        root <= '0;
        cnt  <= CNT_W'(RES_W);
      end else if (cnt != '0) begin
        op   <= op << 2;
        rem  <= ge ? trial - test : trial;
        root <= {root[RES_W-2:0], ge};
        cnt  <= cnt - 1'b1;
        if (cnt == CNT_W'(1)) done <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/rms_norm_stats.sv
// rtl/rms_norm_stats.sv - RMS over NUM_BEATS x ARR_WIDTH lanes; define RMS_EPS_EN to add EPS to the mean
module rms_norm_stats
  import sys_defs::*;
#(
  parameter int NUM_BEATS = 4,
  parameter int EPS       = 1
) (
  input logic             clk,
  input logic             rst,
  rms_norm_stats_if.slave bus
);

  localparam int N_ELEM = ARR_WIDTH * NUM_BEATS;
  localparam int LOG_N  = $clog2(N_ELEM);
  localparam int ACC_W  = 2 * FXP_N + LOG_N;
  localparam int SQ_W   = 2 * FXP_N + $clog2(ARR_WIDTH);
  localparam int RES_W  = FXP_N + 1;
  localparam int IN_W   = 2 * RES_W;
  localparam int BEAT_W = $clog2(NUM_BEATS + 1);
`ifdef RMS_EPS_EN
  localparam bit EPS_EN = 1'b1;
`else
  localparam bit EPS_EN = 1'b0;
`endif
  localparam logic [IN_W-1:0] EPS_ADD = EPS_EN ? IN_W'(EPS) : '0;

  state_t           state, state_nxt;
  logic [ACC_W-1:0] acc;
  logic [BEAT_W-1:0] beat_cnt;
  logic [SQ_W-1:0]  beat_sq;
  prod_t            lane_prod;
  logic             accept, last_beat;
  logic             sq_start, sq_done;
  logic [IN_W-1:0]  sq_in;
  logic [RES_W-1:0] sq_root;
  lane_t            rms_q, rms_nxt;
  logic             zro_q, ovf_q, ovf_nxt;

  always_comb begin
    beat_sq   = '0;
    lane_prod = '0;
    for (int i = 0; i < ARR_WIDTH; i++) begin
      lane_prod = prod_t'(bus.in_vec[i]) * prod_t'(bus.in_vec[i]);
      beat_sq   = beat_sq + SQ_W'(unsigned'(lane_prod));
    end
  end

  assign accept    = bus.in_valid && bus.in_ready;
  assign last_beat = beat_cnt == BEAT_W'(NUM_BEATS - 1);
  // The shift by log2(element count) is a pure bit select of the accumulator.
  assign sq_in     = IN_W'(acc[ACC_W-1:LOG_N]) + EPS_ADD;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (bus.start) state_nxt = ST_ACCUM;
      ST_ACCUM: if (accept && last_beat) state_nxt = ST_MEAN;
      ST_MEAN:  state_nxt = ST_SQRT;
      ST_SQRT:  if (sq_done) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready = state == ST_ACCUM;
    bus.busy     = state != ST_IDLE;
    bus.done     = state == ST_DONE;
    sq_start     = state == ST_MEAN;
  end

  always_comb begin
    ovf_nxt = sq_root >= RES_W'(2 ** (FXP_N - 1));
    rms_nxt = ovf_nxt ? lane_t'(2 ** (FXP_N - 1) - 1) : sq_root[FXP_N-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc      <= '0;
      beat_cnt <= '0;
      rms_q    <= '0;
      zro_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else if (state == ST_IDLE && bus.start) begin
      acc      <= '0;
      beat_cnt <= '0;
      zro_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else if (accept) begin
      acc      <= acc + ACC_W'(beat_sq);
      beat_cnt <= beat_cnt + 1'b1;
    end else if (state == ST_SQRT && sq_done) begin
      rms_q    <= rms_nxt;
      zro_q    <= rms_nxt == '0;
      ovf_q    <= ovf_nxt;
    end
  end

  assign bus.rms_out = {ARR_WIDTH{rms_q}};
  assign bus.zro     = zro_q;
  assign bus.ovf     = ovf_q;

  fxp_isqrt #(
    .IN_W (IN_W)
  ) u_isqrt (
    .clk   (clk),
    .rst   (rst),
    .start (sq_start),
    .din   (sq_in),
    .done  (sq_done),
    .root  (sq_root)
  );

endmodule
